node_injector: RTL

- Per-node host-side injection stage; sits directly upstream of one node_4 router in the network_4 torus.
- Accepts collective requests from the local processor over a valid/ready handshake and buffers them in a small FIFO.
- Formats each request into a FlitChildWidth flit stamped with this node's source coordinates.
- Drives the flit as a one-cycle pulse on the selected inject_* ports, or on reduce_me, with a programmable minimum gap between issues. The router inputs have no backpressure, so this gap is the only rate control.

---
 rtl/node_injector_pkg.sv | 28 ++
 rtl/inj_req_fifo.sv | 33 +++
 rtl/node_injector.sv | 88 ++++++++
 3 files changed

// File: rtl/node_injector_pkg.sv
// node_injector_pkg: packet layout, port-mask indices and injector FSM states
package node_injector_pkg;
  localparam int PayloadWidth   = 32;
  localparam int OpWidth        = 4;
  localparam int AlgWidth       = 2;
  localparam int TagWidth       = 8;
  localparam int CtxWidth       = 8;
  localparam int RankWidth      = 9;
  localparam int CoordWidth     = 9;
  localparam int PayloadPos     = 0;
  localparam int OpPos          = PayloadPos + PayloadWidth;
  localparam int AlgPos         = OpPos + OpWidth;
  localparam int TagPos         = AlgPos + AlgWidth;
  localparam int CtxPos         = TagPos + TagWidth;
  localparam int RankPos        = CtxPos + CtxWidth;
  localparam int SrcPos         = RankPos + RankWidth;
  localparam int DstPos         = SrcPos + CoordWidth;
  localparam int ValidBitPos    = DstPos + CoordWidth;
  localparam int FlitWidth      = ValidBitPos + 1;
  localparam int ChildrenPos    = FlitWidth;
  localparam int ChildrenWidth  = 2;
  localparam int FlitChildWidth = FlitWidth + ChildrenWidth;
  localparam int DirXpos = 0;
  localparam int DirYpos = 1;
  localparam int DirXneg = 2;
  localparam int DirYneg = 3;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} inj_state_t;
endpackage

// File: rtl/inj_req_fifo.sv
// inj_req_fifo: synchronous request FIFO with occupancy count
module inj_req_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int Aw = $clog2(DEPTH),
  localparam int Cw = Aw + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [Cw-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [Aw-1:0] wr, rd;
  assign dout = mem[rd];
  // storage array, no reset needed since count gates every read
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  // pointers and occupancy
  always_ff @(posedge clk)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + Aw'(push);
      rd <= rd + Aw'(pop);
      count <= count + Cw'(push) - Cw'(pop);
    end
endmodule

// File: rtl/node_injector.sv
// node_injector: buffers host requests and issues them as rate-limited flit pulses to the router
module node_injector #(
  parameter logic [2:0] cur_x = 3'd0,
  parameter logic [2:0] cur_y = 3'd0,
  parameter logic [2:0] cur_z = 3'd0,
  parameter int lg_numprocs = 2,
  parameter int PayloadWidth = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int INJECT_GAP = 1,
  localparam int Fcw = PayloadWidth + 50 + lg_numprocs,
  localparam int Cw = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_kind,
  input  logic [PayloadWidth-1:0] req_payload,
  input  logic [3:0]              req_op,
  input  logic [1:0]              req_alg,
  input  logic [7:0]              req_tag,
  input  logic [7:0]              req_ctx,
  input  logic [8:0]              req_rank,
  input  logic [8:0]              req_dst,
  input  logic [3:0]              req_dir_mask,
  input  logic [lg_numprocs-1:0]  req_children,
  output logic [Fcw-1:0]          inject_xpos,
  output logic [Fcw-1:0]          inject_ypos,
  output logic [Fcw-1:0]          inject_xneg,
  output logic [Fcw-1:0]          inject_yneg,
  output logic [Fcw-1:0]          reduce_me,
  output logic [Cw-1:0]           pending,
  output logic [15:0]             sent_count,
  output logic [15:0]             drop_count
);
  import node_injector_pkg::*;
  logic [Fcw-1:0] flit_in, flit;
  logic [Fcw+4:0] head;
  logic kind, pop, load, drop;
  logic [3:0] mask, gap_cnt;
  inj_state_t state, state_nx;
  assign flit_in = {req_children, 1'b1, req_dst, cur_z, cur_y, cur_x, req_rank, req_ctx, req_tag,
                    req_alg, req_op, req_payload};
  assign req_ready = !rst && pending < Cw'(FIFO_DEPTH);
  assign {kind, mask, flit} = head;
  assign drop = !kind && mask == 4'd0;
  inj_req_fifo #(.W(Fcw + 5), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(req_valid && req_ready), .pop(pop),
    .din({req_kind, req_dir_mask, flit_in}), .dout(head), .count(pending)
  );
  // pop whenever the spacing window has elapsed; the last gap cycle pops directly to keep 1+gap spacing
  always_comb begin
    pop = pending != '0 && (state == IDLE || (state == ISSUE && INJECT_GAP == 0) ||
                            (state == GAP && gap_cnt == 4'd0));
    load = pop && !drop;
    state_nx = load ? ISSUE :
               state == ISSUE ? (INJECT_GAP == 0 ? IDLE : GAP) :
               (state == GAP && gap_cnt == 4'd0) ? IDLE : state;
  end
  // state register and gap countdown
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      gap_cnt <= '0;
    end else begin
      state <= state_nx;
      gap_cnt <= state == ISSUE ? 4'(INJECT_GAP - 1) : gap_cnt - 4'(state == GAP);
    end
  // one-cycle flit pulses and saturating statistics
  always_ff @(posedge clk)
    if (rst) begin
      inject_xpos <= '0;
      inject_ypos <= '0;
      inject_xneg <= '0;
      inject_yneg <= '0;
      reduce_me <= '0;
      sent_count <= '0;
      drop_count <= '0;
    end else begin
      inject_xpos <= load && !kind && mask[DirXpos] ? flit : '0;
      inject_ypos <= load && !kind && mask[DirYpos] ? flit : '0;
      inject_xneg <= load && !kind && mask[DirXneg] ? flit : '0;
      inject_yneg <= load && !kind && mask[DirYneg] ? flit : '0;
      reduce_me <= load && kind ? flit : '0;
      sent_count <= sent_count + 16'(load && sent_count != 16'hFFFF);
      drop_count <= drop_count + 16'(pop && drop && drop_count != 16'hFFFF);
    end
endmodule
